// File: rtl/nios_pixel_bridge.sv
// nios_pixel_bridge: packs pixel beats into Nios words, buffers them in a FIFO and hands them over by strobe/ack
// Build option: define NIOS_ACK_TIMEOUT_EN to discard a presented word after TIMEOUT cycles without ack.
// Ports:
//   clk_clk, reset_reset_n            single clock, async active-low reset
//   enable, frame_start               capture enable, frame resync pulse (clears the partial word)
//   pix_valid, pix_data, pix_ready    pixel beat in (channel 0 in LSBs); ready = FIFO not full
//   clk2nios_export, data2nios_export word strobe and word to the Nios PIO
//   ack_from_nios                     Nios acknowledge (four-phase)
//   fifo_level                        registered FIFO occupancy
//   overflow, timeout, clear_status   sticky status bits and their clear
module nios_pixel_bridge #(
    parameter int NUM_CH  = 2,
    parameter int PIX_W   = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       enable,
    input  logic                       frame_start,
    input  logic                       pix_valid,
    input  logic [NUM_CH*PIX_W-1:0]    pix_data,
    output logic                       pix_ready,
    output logic                       clk2nios_export,
    output logic [DATA_W-1:0]          data2nios_export,
    input  logic                       ack_from_nios,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       timeout,
    input  logic                       clear_status
);
    localparam int BEAT_W = NUM_CH * PIX_W;
    localparam int PACK   = DATA_W / BEAT_W;
    localparam int CW     = PACK > 1 ? $clog2(PACK) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, k;
    logic [DATA_W-1:0]  pack_q, word, data_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        level_q, level_d;
    logic               accept, drop, push, pop, load, tmo_hit, strobe_q, ovf_q;

    assign pix_ready = level_q != FULL;
    assign accept    = pix_valid && enable && pix_ready;
    assign drop      = pix_valid && enable && !pix_ready;
    // frame_start makes a beat accepted in the same cycle slot 0 of the new word
    assign k         = frame_start ? '0 : cnt_q;
    assign push      = accept && k == CW'(PACK - 1);
    assign cnt_d     = (drop || push) ? '0 : accept ? k + 1'b1 : frame_start ? '0 : cnt_q;
    assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        word = pack_q;
        word[k*BEAT_W +: BEAT_W] = pix_data;
    end

`ifdef NIOS_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    logic          tmo_q;
    assign tmo_hit = tcnt_q == TW'(TIMEOUT - 1);
    assign timeout = tmo_q;
    // counter is zero on every entry to PRESENT because it only runs there
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= state_q == PRESENT ? tcnt_q + 1'b1 : '0;
            tmo_q  <= (state_q == PRESENT && !ack_from_nios && tmo_hit) || (tmo_q && !clear_status);
        end
`else
    assign tmo_hit = 1'b0;
    assign timeout = TIMEOUT < 0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE:    if (level_q != '0) begin
                         state_d = PRESENT;
                         load    = 1'b1;
                     end
            PRESENT: if (ack_from_nios || tmo_hit) begin
                         state_d = RELEASE;
                         pop     = 1'b1;
                     end
            RELEASE: state_d = ack_from_nios ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk)
        if (push) mem_q[wr_q] <= word;

    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pack_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            if (accept) pack_q <= word;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (load) data_q <= mem_q[rd_q];
            strobe_q <= state_d == PRESENT;
            ovf_q    <= drop || (ovf_q && !clear_status);
        end

    assign clk2nios_export  = strobe_q;
    assign data2nios_export = data_q;
    assign fifo_level       = level_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_nios_pixel_bridge.sv
// tb_nios_pixel_bridge: directed stimulus, per-cycle comparison against a queue-based bridge model
module tb_nios_pixel_bridge;
    localparam int DEPTH = 16;
    localparam int PACK  = 2;
    localparam int TMO   = 8;

    logic        clk = 0, rst_n = 0, enable = 0, frame_start = 0, pix_valid = 0, clear_status = 0;
    logic [15:0] pix_data = 0;
    logic        ack, ack_r = 0, auto_ack = 0, man_ack = 0;
    logic        pix_ready, strobe, ovf, tmo;
    logic [31:0] data;
    logic [4:0]  level;
    int          checks = 0, errors = 0;

    nios_pixel_bridge #(.NUM_CH(2), .PIX_W(8), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .clk2nios_export(strobe), .data2nios_export(data), .ack_from_nios(ack),
        .fifo_level(level), .overflow(ovf), .timeout(tmo), .clear_status(clear_status));

    always #5 clk = ~clk;

    // Nios emulation: ack follows the strobe one cycle later, changed away from the edge
    always @(posedge clk) begin
        #2;
        ack_r = strobe;
    end
    assign ack = auto_ack ? ack_r : man_ack;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // model: FIFO as a queue, Nios side as phase 0 idle / 1 presenting / 2 waiting for ack low
    logic [31:0] q[$];
    logic [31:0] seen[$];
    int          ph = 0, pcnt = 0, tc = 0;
    logic [31:0] pw = 0, m_data = 0;
    logic        m_strobe = 0, m_ovf = 0, m_tmo = 0, full_m, drop_m, tmo_ev, prev_strobe = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ph = 0; pcnt = 0; tc = 0; pw = 0;
            m_data = 0; m_strobe = 0; m_ovf = 0; m_tmo = 0;
        end else begin
            full_m = q.size() == DEPTH;
            drop_m = 0;
            tmo_ev = 0;
            if (ph == 0) begin
                if (q.size() > 0) begin
                    ph = 1; m_data = q[0]; m_strobe = 1; tc = 0;
                end
            end else if (ph == 1) begin
                if (ack) begin
                    void'(q.pop_front()); ph = 2; m_strobe = 0;
                end
`ifdef NIOS_ACK_TIMEOUT_EN
                else begin
                    tc++;
                    if (tc == TMO) begin
                        void'(q.pop_front()); ph = 2; m_strobe = 0; tmo_ev = 1;
                    end
                end
`endif
            end else if (!ack) ph = 0;
            if (frame_start) pcnt = 0;
            if (pix_valid && enable) begin
                if (full_m) begin
                    drop_m = 1; pcnt = 0;
                end else begin
                    pw[pcnt*16 +: 16] = pix_data;
                    pcnt++;
                    if (pcnt == PACK) begin
                        q.push_back(pw); pcnt = 0;
                    end
                end
            end
            m_ovf = drop_m | (m_ovf & ~clear_status);
            m_tmo = tmo_ev | (m_tmo & ~clear_status);
        end
    end

    always @(negedge clk) begin
        chk("level", level, q.size());
        chk("pix_ready", pix_ready, q.size() != DEPTH);
        chk("strobe", strobe, m_strobe);
        chk("data", data, m_data);
        chk("overflow", ovf, m_ovf);
        chk("timeout", tmo, m_tmo);
        if (strobe && !prev_strobe) seen.push_back(data);
        prev_strobe = strobe;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic beat(input logic [15:0] d);
        pix_valid = 1;
        pix_data = d;
        step();
        pix_valid = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && !(q.size() == 0 && ph == 0); i++) step();
        chk("drain_bound", i < 400, 1);
    endtask

    initial begin
        int n0, n;
        step(2);
        chk("rst_level", level, 0);
        chk("rst_ready", pix_ready, 1);
        chk("rst_strobe", strobe, 0);
        chk("rst_data", data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tmo", tmo, 0);
        rst_n = 1;
        enable = 1;
        step();
        // single word: strobe two edges after the first beat
        beat(16'h2211);
        beat(16'h4433);
        step();
        chk("t1_strobe", strobe, 1);
        chk("t1_data", data, 32'h44332211);
        man_ack = 1;
        step();
        chk("t1_release", strobe, 0);
        chk("t1_level", level, 0);
        man_ack = 0;
        step(2);
        // fill 16 words, 17th word dropped
        for (int i = 0; i < 34; i++) beat(16'(i * 16'h0101));
        step();
        chk("t2_level", level, 16);
        chk("t2_ready", pix_ready, 0);
        chk("t2_ovf", ovf, 1);
        clear_status = 1;
        step();
        clear_status = 0;
        chk("t2_clear", ovf, 0);
        auto_ack = 1;
        wait_idle();
        // frame resync discards the partial word
        n0 = seen.size();
        beat(16'hAAAA);
        frame_start = 1;
        beat(16'h1111);
        frame_start = 0;
        beat(16'h2222);
        wait_idle();
        chk("t3_count", seen.size() - n0, 1);
        chk("t3_word", seen[$], 32'h22221111);
        // enable low holds the pack counter
        n0 = seen.size();
        beat(16'h1234);
        enable = 0;
        for (int i = 0; i < 5; i++) beat(16'hDEAD);
        step(3);
        chk("t4_level", level, 0);
        chk("t4_ovf", ovf, 0);
        chk("t4_none", seen.size() - n0, 0);
        enable = 1;
        beat(16'h5678);
        wait_idle();
        chk("t4_word", seen[$], 32'h56781234);
        // reset in the middle of a presentation
        auto_ack = 0;
        for (int i = 0; i < 6; i++) beat(16'h0F0F + 16'(i));
        step();
        chk("t5_strobe", strobe, 1);
        chk("t5_level", level, 3);
        #1 rst_n = 0;
        #1;
        chk("t5_async_strobe", strobe, 0);
        chk("t5_async_level", level, 0);
        step();
        rst_n = 1;
        n0 = seen.size();
        step(6);
        chk("t5_after", strobe, 0);
        chk("t5_none", seen.size() - n0, 0);
`ifdef NIOS_ACK_TIMEOUT_EN
        beat(16'h0201); beat(16'h0403);
        beat(16'h0605); beat(16'h0807);
        // strobe rose one edge before this loop; TMO edges in total
        n = 0;
        while (strobe && n < 50) begin step(); n++; end
        chk("t6_cycles", n, TMO - 1);
        chk("t6_tmo", tmo, 1);
        n = 0;
        while (!strobe && n < 50) begin step(); n++; end
        chk("t6_next", data, 32'h08070605);
        auto_ack = 1;
        wait_idle();
`else
        n = 0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios_pixel_bridge.md
# nios_pixel_bridge

Parametrised pixel-to-Nios bridge. Replaces the fixed img/clk2nios/data2nios export path in the tracking system. It accepts NUM_CH parallel pixel channels per beat and packs whole beats into DATA_W-bit words. Words are buffered in a DEPTH-entry FIFO and handed to the Nios PIO through a four-phase strobe/ack handshake. Overflow is recorded in sticky status bits, and the block supports frame resynchronisation.

## Interface
Parameters:
- NUM_CH, 2: pixel channels per beat.
- PIX_W, 8: bits per channel pixel.
- DATA_W, 32: Nios word width. Must be an integer multiple of NUM_CH*PIX_W. PACK = DATA_W/(NUM_CH*PIX_W), 2 by default.
- DEPTH, 16: FIFO entries. Power of two, ≥2.
- TIMEOUT, 1023: ack timeout in cycles. Used only with NIOS_ACK_TIMEOUT_EN.

Ports:
- clk_clk  in  1  system clock, the single clock domain.
- reset_reset_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  capture enable.
- frame_start  in  1  one-cycle frame sync pulse.
- pix_valid  in  1  pixel beat present.
- pix_data  in  NUM_CH*PIX_W  channel 0 is in the LSBs.
- pix_ready  out  1  high when the FIFO is not full. Informational only; upstream cannot stall.
- clk2nios_export  out  1  word strobe to Nios.
- data2nios_export  out  DATA_W  word presented to Nios.
- ack_from_nios  in  1  Nios acknowledge.
- fifo_level  out  $clog2(DEPTH)+1  registered FIFO occupancy.
- overflow  out  1  sticky: a beat was dropped.
- timeout  out  1  sticky: a word was discarded on ack timeout.
- clear_status  in  1  clears overflow and timeout.

## Operation
- Packer:
  - A beat is accepted when pix_valid && enable && pix_ready.
  - Accepted beat k (0..PACK-1) is written to bits [k*NUM_CH*PIX_W +: NUM_CH*PIX_W] of the pack register, so the first beat lands in the LSBs.
  - The beat with k = PACK-1 pushes the completed word (including itself) into the FIFO in the same cycle, and the pack counter returns to 0.
- Drop:
  - A beat with pix_valid && enable && !pix_ready is discarded.
  - The pack counter resets to 0, so the partial word is lost.
  - overflow is set.
- enable low: beats are ignored without setting overflow. The pack counter is held. The output side keeps draining.
- frame_start:
  - Resets the pack counter to 0 regardless of enable, discarding any partial word.
  - If a beat is accepted in the same cycle, it becomes beat 0 of the new frame.
- FIFO:
  - pix_ready = (fifo_level != DEPTH), using the registered level.
  - A push while full cannot occur, because full beats are dropped.
  - A simultaneous push and pop leaves the level unchanged.
- Output FSM, states IDLE, PRESENT, RELEASE:
  - IDLE → PRESENT when the FIFO is non-empty. On this transition, data2nios_export is loaded from the FIFO head and clk2nios_export goes 1.
  - PRESENT → RELEASE on ack_from_nios = 1. On this transition the FIFO pops and clk2nios_export goes 0. data2nios_export holds its value.
  - RELEASE → IDLE on ack_from_nios = 0.
  - ack_from_nios is ignored in IDLE.
- Status:
  - clear_status clears overflow and timeout.
  - If a set event and clear_status occur in the same cycle, the set wins.

## Timing
- Reset values: clk2nios_export 0, data2nios_export 0, fifo_level 0, overflow 0, timeout 0, pix_ready 1. FSM enters IDLE, pack counter 0, FIFO empty.
- Reset asserted mid-handshake drops the strobe asynchronously and clears the FIFO contents.
- Latency: completing beat sampled at edge N, word written at edge N, strobe high after edge N+1 (FIFO was empty and FSM in IDLE).
- fifo_level updates on the edge after each push or pop.
- Back-to-back words: at least 3 cycles per word (IDLE → PRESENT → RELEASE → IDLE), plus ack latency.
- All outputs are registered except pix_ready. pix_ready is decoded from registered fifo_level.

## Configuration
- NIOS_ACK_TIMEOUT_EN defined:
  - A counter runs while in PRESENT.
  - If TIMEOUT cycles pass with no ack, the FIFO head is popped (discarded), clk2nios_export drops, the FSM goes to RELEASE, and timeout is set.
  - The counter clears on every entry to PRESENT.
- NIOS_ACK_TIMEOUT_EN undefined: the FSM waits for ack indefinitely, timeout is tied to 0, and no counter logic is generated.

## Test plan
- Defaults, enable = 1, beats 0x2211 then 0x4433 → one FIFO word. Strobe rises 2 cycles after the first beat's edge with data2nios_export = 0x44332211. Ack high → strobe low next cycle, fifo_level 0.
- 17 words pushed with Nios idle → fifo_level = 16, pix_ready = 0. Both beats of the 17th word dropped, overflow = 1. clear_status → overflow = 0.
- Beat 0xAAAA, then frame_start together with beat 0x1111, then beat 0x2222 → only word 0x22221111 is emitted.
- enable = 0 with 5 beats → no words, overflow stays 0. enable = 1 resumes from the held pack counter.
- Reset asserted while in PRESENT with 3 words queued → strobe 0 immediately, fifo_level 0, no word emitted after release.
- NIOS_ACK_TIMEOUT_EN, TIMEOUT = 8, no ack → strobe drops after 8 cycles and timeout = 1. The next word is presented after ack stays low.
